// File: rtl/trajectory_engine.sv
`default_nettype none
// ============================================================================
// Module   : trajectory_engine
// Purpose  : Queues cannon shots in a small FIFO and flies each one as a
//            ballistic trajectory, one step per clock, reporting hit/miss
//            against a live target position.
// Ports    : clk, reset (sync, active-high), ena (global hold)
//            shoot, x_pos, rise_in, run_in, direction_in -> shot request
//            wind_in (signed x drift per step, WIND_EN=1 only)
//            target_x, target_y -> live target, sampled every step
//            result_valid, hit -> shot outcome
//            positionx, positiony -> current projectile position
//            busy, queue_full, shot_dropped -> status
// Revision : 1.0  initial release
// ============================================================================
module trajectory_engine #(
  parameter int GRID_W    = 5,
  parameter int DEPTH     = 2,
  parameter int TOL       = 1,
  parameter int MAX_STEPS = 31,
  parameter int WIND_EN   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              shoot,
  input  logic [GRID_W-1:0] x_pos,
  input  logic [GRID_W-1:0] rise_in,
  input  logic [GRID_W-1:0] run_in,
  input  logic              direction_in,
  input  logic [1:0]        wind_in,
  input  logic [GRID_W-1:0] target_x,
  input  logic [GRID_W-1:0] target_y,
  output logic              result_valid,
  output logic              hit,
  output logic [GRID_W-1:0] positionx,
  output logic [GRID_W-1:0] positiony,
  output logic              busy,
  output logic              queue_full,
  output logic              shot_dropped
);

  localparam int SW  = GRID_W + 2;                    // signed internal width
  localparam int EW  = 3 * GRID_W + 1;                // FIFO entry width
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int STW = $clog2(MAX_STEPS + 1);

  localparam logic signed [SW-1:0] c_XMAX = SW'((1 << GRID_W) - 1);
  localparam logic signed [SW-1:0] c_TOL  = SW'(TOL);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;

  state_t                  r_state;
  logic [EW-1:0]           r_mem [DEPTH];
  logic [PW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_count;
  logic [GRID_W-1:0]       r_run;
  logic                    r_dir;
  logic signed [SW-1:0]    r_px, r_py, r_vy;
  logic [STW-1:0]          r_steps;
  logic                    r_result_valid, r_hit, r_shot_dropped;
  logic [GRID_W-1:0]       r_posx, r_posy;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------- FIFO control ----------------
  logic w_full, w_pop, w_push, w_drop;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = ena && (r_state == S_LOAD);
  // A pop on the same edge frees a slot, so a shoot into a full queue is
  // still accepted then.
  assign w_push = !reset && ena && shoot && (!w_full || w_pop);
  assign w_drop = ena && shoot && w_full && !w_pop;

  logic [EW-1:0]     w_head;
  logic [GRID_W-1:0] w_hx, w_hrise, w_hrun;
  logic              w_hdir;
  assign w_head  = r_mem[r_rd];
  assign w_hx    = w_head[2*GRID_W+1 +: GRID_W];
  assign w_hrise = w_head[GRID_W+1 +: GRID_W];
  assign w_hrun  = w_head[1 +: GRID_W];
  assign w_hdir  = w_head[0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {x_pos, rise_in, run_in, direction_in};
  end

  // ---------------- one trajectory step ----------------
  logic signed [SW-1:0] w_runx, w_wind, w_px_n, w_py_n, w_ty, w_dx, w_adx;
  logic [STW-1:0]       w_steps_n;
  logic                 w_out, w_land, w_maxed, w_end, w_hit_n;

  assign w_runx    = $signed({2'b00, r_run});
  assign w_wind    = (WIND_EN != 0) ? $signed({{GRID_W{wind_in[1]}}, wind_in}) : '0;
  assign w_px_n    = r_dir ? (r_px + w_runx + w_wind) : (r_px - w_runx + w_wind);
  assign w_py_n    = r_py + r_vy;
  assign w_steps_n = r_steps + STW'(1);
  assign w_ty      = $signed({2'b00, target_y});
  // Once the x-range test passes, px' lies in 0..2^GRID_W-1, so the
  // difference to the target fits in SW bits.
  assign w_dx      = w_px_n - $signed({2'b00, target_x});
  assign w_adx     = w_dx[SW-1] ? -w_dx : w_dx;

  assign w_out     = w_px_n[SW-1] || (w_px_n > c_XMAX);
  assign w_land    = r_vy[SW-1] && (w_py_n <= w_ty);      // descending only
  assign w_maxed   = (w_steps_n == STW'(MAX_STEPS));
  assign w_end     = w_out || w_land || w_maxed;
  assign w_hit_n   = !w_out && w_land && (w_adx <= c_TOL);

  // ---------------- FSM + queue pointers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wr           <= '0;
      r_rd           <= '0;
      r_count        <= '0;
      r_run          <= '0;
      r_dir          <= 1'b0;
      r_px           <= '0;
      r_py           <= '0;
      r_vy           <= '0;
      r_steps        <= '0;
      r_result_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_shot_dropped <= 1'b0;
      r_posx         <= '0;
      r_posy         <= '0;
    end else if (ena) begin
      r_shot_dropped <= w_drop;
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      case (r_state)
        S_IDLE: begin
          r_result_valid <= 1'b0;
          if (r_count != '0) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_px    <= $signed({2'b00, w_hx});
          r_py    <= '0;
          r_vy    <= $signed({2'b00, w_hrise});
          r_run   <= w_hrun;
          r_dir   <= w_hdir;
          r_steps <= '0;
          r_posx  <= w_hx;
          r_posy  <= '0;
          r_state <= S_STEP;
        end
        S_STEP: begin
          r_px    <= w_px_n;
          r_py    <= w_py_n;
          r_vy    <= r_vy - SW'(1);
          r_steps <= w_steps_n;
          r_posx  <= w_px_n[GRID_W-1:0];
          r_posy  <= w_py_n[GRID_W-1:0];
          if (w_end) begin
            r_hit          <= w_hit_n;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        default: begin  // S_DONE
          r_result_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  // Pulses are masked while held so they never stretch across a freeze.
  assign result_valid = r_result_valid & ena;
  assign shot_dropped = r_shot_dropped & ena;
  assign hit          = r_hit;
  assign positionx    = r_posx;
  assign positiony    = r_posy;
  assign busy         = (r_state != S_IDLE);
  assign queue_full   = w_full;

endmodule
`default_nettype wire

// File: tb/tb_trajectory_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_trajectory_engine
// Purpose  : Directed self-checking bench for trajectory_engine. Two
//            instances share stimulus: one without wind, one with wind.
// Revision : 1.0  initial release
// ============================================================================
module tb_trajectory_engine;

  logic       clk = 1'b0;
  logic       reset, ena, shoot, direction_in;
  logic [4:0] x_pos, rise_in, run_in, target_x, target_y;
  logic [1:0] wind_in;

  logic       rv, hit, busy, qfull, dropped;
  logic [4:0] posx, posy;
  logic       rv_w, hit_w, busy_w, qfull_w, dropped_w;
  logic [4:0] posx_w, posy_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trajectory_engine #(.GRID_W(5), .DEPTH(2), .TOL(1), .MAX_STEPS(31), .WIND_EN(0)) dut (
    .clk(clk), .reset(reset), .ena(ena), .shoot(shoot),
    .x_pos(x_pos), .rise_in(rise_in), .run_in(run_in), .direction_in(direction_in),
    .wind_in(wind_in), .target_x(target_x), .target_y(target_y),
    .result_valid(rv), .hit(hit), .positionx(posx), .positiony(posy),
    .busy(busy), .queue_full(qfull), .shot_dropped(dropped)
  );

  trajectory_engine #(.GRID_W(5), .DEPTH(2), .TOL(1), .MAX_STEPS(31), .WIND_EN(1)) dut_w (
    .clk(clk), .reset(reset), .ena(ena), .shoot(shoot),
    .x_pos(x_pos), .rise_in(rise_in), .run_in(run_in), .direction_in(direction_in),
    .wind_in(wind_in), .target_x(target_x), .target_y(target_y),
    .result_valid(rv_w), .hit(hit_w), .positionx(posx_w), .positiony(posy_w),
    .busy(busy_w), .queue_full(qfull_w), .shot_dropped(dropped_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_shot(input logic [4:0] x, r, rn, input logic d, input logic [4:0] tx, ty);
    x_pos = x; rise_in = r; run_in = rn; direction_in = d;
    target_x = tx; target_y = ty;
  endtask

  // Fire one shot and count cycles from the shoot cycle to result_valid.
  task automatic do_shot(input logic [4:0] x, r, rn, input logic d, input logic [4:0] tx, ty,
                         input bit use_w, output int lat, output logic h, output logic [4:0] px);
    set_shot(x, r, rn, d, tx, ty);
    shoot = 1'b1;
    step();
    lat = 1;
    shoot = 1'b0;
    while (!(use_w ? rv_w : rv) && lat < 60) begin
      step();
      lat++;
    end
    h  = use_w ? hit_w : hit;
    px = use_w ? posx_w : posx;
    step();
    step();
  endtask

  int         lat, cyc, nrv;
  logic       h;
  logic [4:0] px;
  int         rvs[$];
  logic [4:0] tgt_tab[4] = '{5'd24, 5'd22, 5'd21, 5'd20};
  logic       exp_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b0; ena = 1'b1; shoot = 1'b0; wind_in = 2'b00;
    set_shot(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    step();
    apply_reset();

    // Reset state
    chk("rst_rv",      rv,      0);
    chk("rst_hit",     hit,     0);
    chk("rst_posx",    posx,    0);
    chk("rst_posy",    posy,    0);
    chk("rst_busy",    busy,    0);
    chk("rst_qfull",   qfull,   0);
    chk("rst_dropped", dropped, 0);

    // Nominal hit: 7 steps, landing at (23,0)
    do_shot(5'd2, 5'd3, 5'd3, 1'b1, 5'd23, 5'd0, 1'b0, lat, h, px);
    chk("hit_lat",  lat, 10);
    chk("hit_hit",  h,   1);
    chk("hit_posx", px,  23);
    chk("hit_posy", posy, 0);
    chk("hit_held", hit, 1);

    // Tolerance boundary around px'=23
    for (int i = 0; i < 4; i++) begin
      do_shot(5'd2, 5'd3, 5'd3, 1'b1, tgt_tab[i], 5'd0, 1'b0, lat, h, px);
      chk("tol_lat", lat, 10);
      chk("tol_hit", h,   exp_tab[i]);
    end

    // Out of range on first step: px'=34
    do_shot(5'd30, 5'd3, 5'd4, 1'b1, 5'd23, 5'd0, 1'b0, lat, h, px);
    chk("oor_lat",  lat, 4);
    chk("oor_hit",  h,   0);
    chk("oor_posx", px,  2);

    // Queue: A in flight, then four consecutive shoots
    apply_reset();
    set_shot(5'd2, 5'd3, 5'd3, 1'b1, 5'd23, 5'd0);
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    step(); step();
    cyc = 3;
    shoot = 1'b1;
    step(); cyc++;
    chk("q1_full", qfull, 0);
    chk("q1_drop", dropped, 0);
    step(); cyc++;
    chk("q2_full", qfull, 1);
    chk("q2_drop", dropped, 0);
    step(); cyc++;
    chk("q3_full", qfull, 1);
    chk("q3_drop", dropped, 1);
    step(); cyc++;
    chk("q4_drop", dropped, 1);
    shoot = 1'b0;
    step(); cyc++;
    chk("q5_drop", dropped, 0);
    while (cyc < 60) begin
      step(); cyc++;
      if (rv) rvs.push_back(cyc);
    end
    chk("q_nres", rvs.size(), 3);
    chk("q_res0", (rvs.size() > 0) ? rvs[0] : -1, 10);
    chk("q_res1", (rvs.size() > 1) ? rvs[1] : -1, 20);
    chk("q_res2", (rvs.size() > 2) ? rvs[2] : -1, 30);
    chk("q_idle", busy, 0);

    // Reset in the middle of STEP
    apply_reset();
    set_shot(5'd2, 5'd3, 5'd3, 1'b1, 5'd23, 5'd0);
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    step(); step(); step(); step();
    chk("mr_busy_pre", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_posx", posx, 0);
    chk("mr_posy", posy, 0);
    nrv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rv) nrv++;
    end
    chk("mr_nores", nrv, 0);

    // ena=0 freezes mid-flight for 5 cycles; shoot during freeze is ignored
    apply_reset();
    set_shot(5'd2, 5'd3, 5'd3, 1'b1, 5'd23, 5'd0);
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    step(); step(); step();
    chk("en_posx_pre", posx, 5);
    ena = 1'b0;
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    step(); step(); step(); step();
    chk("en_posx_frz", posx, 5);
    chk("en_busy_frz", busy, 1);
    ena = 1'b1;
    lat = 9;
    while (!rv && lat < 60) begin
      step();
      lat++;
    end
    chk("en_lat", lat, 15);
    chk("en_hit", hit, 1);
    nrv = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rv) nrv++;
    end
    chk("en_noextra", nrv, 0);

    // Wind -1: px advances 2 per step, lands at 16 after 7 steps
    apply_reset();
    wind_in = 2'b11;
    do_shot(5'd2, 5'd3, 5'd3, 1'b1, 5'd23, 5'd0, 1'b1, lat, h, px);
    chk("wind_lat",  lat, 10);
    chk("wind_hit",  h,   0);
    chk("wind_posx", px,  16);
    do_shot(5'd2, 5'd3, 5'd3, 1'b1, 5'd15, 5'd0, 1'b1, lat, h, px);
    chk("wind2_lat", lat, 10);
    chk("wind2_hit", h,   1);
    wind_in = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
